fp_div: RTL and testbench
=========================

Name: fp_div

Overview:
- Sequential IEEE-754 single-precision divider, z = a / b. It is the inverse-operation companion to the combinational fp_mult datapath.
- Same rounding modes (rounding_mode_t from package rounding_modes) and same status byte layout as the multiplier. Bit 6 is additionally used for divide-by-zero.
- Iterative restoring mantissa division behind a start/busy/done handshake, with fixed latency. Used where a shared, low-area divide is acceptable.

Parameters:
- RADIX_BITS, 1, quotient bits resolved per cycle. Legal values: 1 or 2.
- ITER, 26/RADIX_BITS, derived, not overridable: number of divide cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request. Sampled only when busy=0.
- a  in  32  dividend. Captured on an accepted start.
- b  in  32  divisor. Captured on an accepted start.
- rnd  in  rounding_mode_t (3)  rounding mode. Captured on an accepted start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  single-cycle pulse; z and status are valid in this cycle.
- z  out  32  quotient. Held until the next accepted start.
- status  out  8  {1'b0, dbz_f, inexact_f, huge_f, tiny_f, nan_f, inf_f, zero_f}. Held like z.

Behaviour:
- Reset: clk/rst is one clock domain; reset is asynchronous, active-high. Reset forces state=IDLE, busy=0, done=0, z=0, status=0, and clears all internal registers. Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, DIV, ROUND, DONE.
- IDLE: start=1 latches a, b and rnd; next state is DIV.
- DIV: runs ITER cycles, then moves to ROUND.
- ROUND: one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 in DONE.
- Latency: start accepted at edge 0; done high during cycle ITER+2 (28 for RADIX_BITS=1). Latency is identical for special operands; their result overrides the datapath result.
- start while busy or in DONE is ignored. It is not queued.
- Decode: exponent field 0 is treated as zero, so denormals are flushed. Exponent 255 with mantissa 0 is inf; with mantissa nonzero it is NaN.
- Sign: z sign = a[31] ^ b[31] for every result except NaN.
- Mantissa division: R = {1, ma} (25 bits), D = {1, mb}. For each of 26 quotient bits: if R >= D then q=1 and R = R - D, else q=0; then R = R << 1.
- If q[25]=1: mant = q[25:2], guard = q[1], sticky = q[0] | (R != 0), exp = ea - eb + 127.
- Otherwise: mant = q[24:1], guard = q[0], sticky = (R != 0), exp = ea - eb + 126.
- Exponent arithmetic is signed, 10 bits.
- Rounding per rnd, same semantics as the multiplier:
  - IEEE_near: nearest, ties to even.
  - IEEE_zero: toward zero.
  - IEEE_pinf: toward +inf.
  - IEEE_ninf: toward -inf.
  - near_up: nearest, ties away.
  - away_zero: away from zero.
- If rounding carries out to 2.0: mantissa becomes 1.0 and exp increments.
- Underflow (tiny_f): normalized exp < 1, evaluated pre-round.
  - IEEE_near, near_up, IEEE_zero: signed zero.
  - away_zero: signed min-normal 0x00800000.
  - IEEE_pinf: +min-normal if positive, -0 if negative.
  - IEEE_ninf: -min-normal if negative, +0 if positive.
- Overflow (huge_f): post-round exp > 254.
  - IEEE_near, near_up, away_zero: signed inf.
  - IEEE_zero: signed max-normal 0x7F7FFFFF.
  - IEEE_pinf: +inf if positive, -max-normal if negative.
  - IEEE_ninf: -inf if negative, +max-normal if positive.
- inexact_f = guard | sticky | tiny_f | huge_f, for finite non-special results only.
- Special cases (tiny, huge and inexact are 0):
  - Either operand NaN, 0/0, or inf/inf: z = 0x7FC00000, nan_f=1.
  - finite nonzero / 0: signed inf, inf_f=1, dbz_f=1.
  - inf / finite: signed inf, inf_f=1.
  - finite / inf, or 0 / nonzero: signed zero, zero_f=1.
- zero_f and inf_f also reflect the final z: zero_f=1 when exponent and mantissa are 0; inf_f=1 when z is ±inf.

Test Plan:
- a=0x40C00000, b=0x40000000, rnd=IEEE_near -> z=0x40400000, status=0x00. done exactly 28 cycles after start; busy high in cycles 1..27.
- a=0x3F800000, b=0x40400000 (1/3) -> IEEE_near: z=0x3EAAAAAB, status=0x20. IEEE_zero: z=0x3EAAAAAA, status=0x20.
- a=0x3F800000, b=0x00000000 -> z=0x7F800000, status=0x42. Same inputs with a=0x00000000 -> z=0x7FC00000, status=0x04.
- a=0x7F000000, b=0x3E800000 -> IEEE_near: z=0x7F800000, status=0x32. IEEE_zero: z=0x7F7FFFFF, status=0x30.
- a=0x00800000, b=0x40800000, IEEE_near -> z=0x00000000, status=0x29. away_zero -> z=0x00800000, status=0x28.
- Pulse start again at cycle 5 with other operands -> ignored; original result returned. Assert rst at cycle 10 -> busy, done, z and status read 0 immediately with no done pulse; next start completes normally.

Source files
------------

// File: rtl/fp_div.sv
// Sequential IEEE-754 single-precision divider (z = a / b) built on a restoring
// mantissa divider behind a start/busy/done handshake with fixed latency.
package rounding_modes;
  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } rounding_mode_t;
endpackage

module fp_div
  import rounding_modes::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [31:0]    a,
  input  logic [31:0]    b,
  input  rounding_mode_t rnd,
  output logic           busy,
  output logic           done,
  output logic [31:0]    z,
  output logic [7:0]     status,
  output logic [1:0]     dbg_state
);
  localparam int ITER = 26 / RADIX_BITS;

  // Handshake: start is accepted only in IDLE; busy covers DIV and ROUND;
  // done pulses for the single DONE cycle, in which z/status are already valid.
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [31:0]    r_a, r_b, r_z;
  logic [7:0]     r_status;
  rounding_mode_t r_rnd;
  logic [24:0]    r_rem;
  logic [25:0]    r_q;
  logic [4:0]     r_cnt;

  logic [24:0] w_den, w_rem_n;
  logic [25:0] w_q_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DIV;
      S_DIV:   if (r_cnt == 5'(ITER - 1)) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_DIV) || (r_state == S_ROUND);
    done      = (r_state == S_DONE);
    z         = r_z;
    status    = r_status;
    dbg_state = r_state;
  end

  // Restoring division: RADIX_BITS quotient bits per cycle; remainder stays < 2*D.
  assign w_den = {2'b01, r_b[22:0]};

  always_comb begin
    w_rem_n = r_rem;
    w_q_n   = r_q;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (w_rem_n >= w_den) begin
        w_q_n   = {w_q_n[24:0], 1'b1};
        w_rem_n = w_rem_n - w_den;
      end else begin
        w_q_n   = {w_q_n[24:0], 1'b0};
      end
      w_rem_n = w_rem_n << 1;
    end
  end

  // Operand decode; a zero exponent field flushes denormals to zero.
  logic [7:0] w_ea, w_eb;
  logic       w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sign;

  always_comb begin
    w_ea     = r_a[30:23];
    w_eb     = r_b[30:23];
    w_a_zero = (w_ea == 8'd0);
    w_b_zero = (w_eb == 8'd0);
    w_a_inf  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
    w_a_nan  = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    w_b_nan  = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    w_sign   = r_a[31] ^ r_b[31];
  end

  logic [22:0]       w_frac_pre, w_frac;
  logic              w_guard, w_sticky, w_up, w_carry, w_tiny, w_huge;
  logic signed [9:0] w_exp, w_exp_r;
  logic [31:0]       w_z;
  logic [7:0]        w_status;
  logic              w_nan, w_dbz, w_special;

  always_comb begin
    w_frac_pre = r_q[25] ? r_q[24:2] : r_q[23:1];
    w_guard    = r_q[25] ? r_q[1] : r_q[0];
    w_sticky   = (r_q[25] & r_q[0]) | (r_rem != 25'd0);
    w_exp      = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
               + (r_q[25] ? 10'sd127 : 10'sd126);

    case (r_rnd)
      IEEE_zero: w_up = 1'b0;
      IEEE_pinf: w_up = ~w_sign & (w_guard | w_sticky);
      IEEE_ninf: w_up = w_sign & (w_guard | w_sticky);
      near_up:   w_up = w_guard;
      away_zero: w_up = w_guard | w_sticky;
      default:   w_up = w_guard & (w_sticky | w_frac_pre[0]);
    endcase

    // An all-ones fraction that rounds up wraps to 0 and bumps the exponent (2.0 -> 1.0 * 2).
    {w_carry, w_frac} = {1'b0, w_frac_pre} + 24'(w_up);
    w_exp_r = w_exp + 10'(w_carry);
    w_tiny  = (w_exp < 10'sd1);
    w_huge  = ~w_tiny && (w_exp_r > 10'sd254);

    if (w_tiny) begin
      case (r_rnd)
        away_zero: w_z = {w_sign, 31'h0080_0000};
        IEEE_pinf: w_z = w_sign ? 32'h8000_0000 : 32'h0080_0000;
        IEEE_ninf: w_z = w_sign ? 32'h8080_0000 : 32'h0000_0000;
        default:   w_z = {w_sign, 31'h0000_0000};
      endcase
    end else if (w_huge) begin
      case (r_rnd)
        IEEE_zero: w_z = {w_sign, 31'h7F7F_FFFF};
        IEEE_pinf: w_z = w_sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
        IEEE_ninf: w_z = w_sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        default:   w_z = {w_sign, 31'h7F80_0000};
      endcase
    end else begin
      w_z = {w_sign, w_exp_r[7:0], w_frac};
    end

    w_nan     = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    w_dbz     = 1'b0;
    w_special = 1'b1;
    if (w_nan) begin
      w_z = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      w_z = {w_sign, 31'h7F80_0000};
    end else if (w_b_zero) begin
      w_z   = {w_sign, 31'h7F80_0000};
      w_dbz = 1'b1;
    end else if (w_b_inf || w_a_zero) begin
      w_z = {w_sign, 31'h0000_0000};
    end else begin
      w_special = 1'b0;
    end

    w_status = {1'b0, w_dbz,
                ~w_special & (w_guard | w_sticky | w_tiny | w_huge),
                ~w_special & w_huge,
                ~w_special & w_tiny,
                w_nan,
                (w_z[30:0] == 31'h7F80_0000),
                (w_z[30:0] == 31'h0000_0000)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_rnd    <= IEEE_near;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_z      <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_rnd <= rnd;
          r_rem <= {2'b01, a[22:0]};
          r_q   <= '0;
          r_cnt <= '0;
        end
        S_DIV: begin
          r_rem <= w_rem_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 5'd1;
        end
        S_ROUND: begin
          r_z      <= w_z;
          r_status <= w_status;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: hand-computed quotients/status, latency, busy
// window, ignored mid-operation start and asynchronous reset abort.
module tb_fp_div;
  import rounding_modes::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [31:0]    a, b;
  rounding_mode_t rnd;
  logic           busy, done;
  logic [31:0]    z;
  logic [7:0]     status;
  logic [1:0]     dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_div #(.RADIX_BITS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rnd(rnd),
    .busy(busy), .done(done), .z(z), .status(status), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Accept edge is edge 0; done is expected 27 edges later (cycle 28).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input rounding_mode_t tr,
                        input logic [31:0] ez, input logic [7:0] es, input string tag,
                        input bit stray);
    int n;
    bit busy_ok;
    @(negedge clk);
    a = ta; b = tb; rnd = tr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (stray && n == 4) begin
        a = 32'h3F80_0000; b = 32'h4040_0000; rnd = IEEE_zero; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, 32'd27);
    chk({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_status"}, {24'd0, status}, {24'd0, es});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_z_held"}, z, ez);
  endtask

  initial begin
    bit done_seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; rnd = IEEE_near;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_z", z, 32'd0);
    chk("reset_status", {24'd0, status}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h40C0_0000, 32'h4000_0000, IEEE_near, 32'h4040_0000, 8'h00, "six_by_two", 1'b0);
    run_op(32'hC0C0_0000, 32'h4000_0000, IEEE_near, 32'hC040_0000, 8'h00, "neg_six_by_two", 1'b0);
    run_op(32'h3F80_0000, 32'h4040_0000, IEEE_near, 32'h3EAA_AAAB, 8'h20, "third_near", 1'b0);
    run_op(32'h3F80_0000, 32'h4040_0000, IEEE_zero, 32'h3EAA_AAAA, 8'h20, "third_zero", 1'b0);
    run_op(32'h3F80_0000, 32'h4040_0000, IEEE_pinf, 32'h3EAA_AAAB, 8'h20, "third_pinf", 1'b0);
    run_op(32'hBF80_0000, 32'h4040_0000, IEEE_pinf, 32'hBEAA_AAAA, 8'h20, "neg_third_pinf", 1'b0);
    run_op(32'hBF80_0000, 32'h4040_0000, IEEE_ninf, 32'hBEAA_AAAB, 8'h20, "neg_third_ninf", 1'b0);
    run_op(32'h3F80_0000, 32'h3FFF_FFFF, IEEE_near, 32'h3F00_0001, 8'h20, "near_two_recip", 1'b0);
    run_op(32'h3F80_0000, 32'h0000_0000, IEEE_near, 32'h7F80_0000, 8'h42, "div_by_zero", 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, IEEE_near, 32'h7FC0_0000, 8'h04, "zero_by_zero", 1'b0);
    run_op(32'h7FC0_0001, 32'h3F80_0000, IEEE_near, 32'h7FC0_0000, 8'h04, "nan_in", 1'b0);
    run_op(32'h7F80_0000, 32'h7F80_0000, IEEE_near, 32'h7FC0_0000, 8'h04, "inf_by_inf", 1'b0);
    run_op(32'h7F80_0000, 32'h4000_0000, IEEE_near, 32'h7F80_0000, 8'h02, "inf_by_two", 1'b0);
    run_op(32'hC000_0000, 32'h7F80_0000, IEEE_near, 32'h8000_0000, 8'h01, "neg_two_by_inf", 1'b0);
    run_op(32'h7F00_0000, 32'h3E80_0000, IEEE_near, 32'h7F80_0000, 8'h32, "ovf_near", 1'b0);
    run_op(32'h7F00_0000, 32'h3E80_0000, IEEE_zero, 32'h7F7F_FFFF, 8'h30, "ovf_zero", 1'b0);
    run_op(32'hFF00_0000, 32'h3E80_0000, IEEE_pinf, 32'hFF7F_FFFF, 8'h30, "ovf_neg_pinf", 1'b0);
    run_op(32'h0080_0000, 32'h4080_0000, IEEE_near, 32'h0000_0000, 8'h29, "unf_near", 1'b0);
    run_op(32'h0080_0000, 32'h4080_0000, away_zero, 32'h0080_0000, 8'h28, "unf_away", 1'b0);
    run_op(32'h0080_0000, 32'h4080_0000, IEEE_ninf, 32'h0000_0000, 8'h29, "unf_ninf", 1'b0);
    run_op(32'h40C0_0000, 32'h4000_0000, IEEE_near, 32'h4040_0000, 8'h00, "stray_start", 1'b1);

    // Abort: reset asserted during cycle 10 of an operation.
    run_op(32'h3F80_0000, 32'h4040_0000, IEEE_near, 32'h3EAA_AAAB, 8'h20, "pre_abort", 1'b0);
    @(negedge clk);
    a = 32'h40C0_0000; b = 32'h4000_0000; rnd = IEEE_near; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_z", z, 32'd0);
    chk("abort_status", {24'd0, status}, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, done_seen}, 32'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, IEEE_near, 32'h4040_0000, 8'h00, "after_abort", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
